bsg_activation_share_ctrl: RTL and testbench



---
 rtl/bsg_activation_share_ctrl.sv | 125 ++++++++++++
 tb/tb_bsg_activation_share_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_activation_share_ctrl.sv
// Round-robin arbiter that time-shares one non-pipelined activation unit among
// els_p requesters: accept one argument, issue it, capture the result, return it.
module bsg_activation_share_ctrl #(
  parameter int els_p       = 4,
  parameter int ang_width_p = 21,
  parameter int ans_width_p = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [els_p-1:0]             v_i,
  input  logic [els_p*ang_width_p-1:0] ang_i,
  output logic [els_p-1:0]             ready_o,
  output logic [els_p-1:0]             v_o,
  output logic [ans_width_p-1:0]       data_o,
  input  logic [els_p-1:0]             yumi_i,
  output logic                         unit_v_o,
  output logic [ang_width_p-1:0]       unit_ang_o,
  input  logic                         unit_ready_i,
  input  logic                         unit_v_i,
  input  logic [ans_width_p-1:0]       unit_data_i,
  output logic                         unit_yumi_o,
  output logic                         busy_o
);

  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

  typedef enum logic [1:0] {
    eIDLE   = 2'd0,
    eISSUE  = 2'd1,
    eWAIT   = 2'd2,
    eRETURN = 2'd3
  } state_e;

  state_e                 state_r;
  logic [lg_els_lp-1:0]   rr_ptr_r;
  logic [lg_els_lp-1:0]   owner_r;
  logic [ang_width_p-1:0] ang_r;
  logic [ans_width_p-1:0] data_r;

  logic [lg_els_lp-1:0]   grant_s;
  logic                   grant_v_s;
  logic [lg_els_lp-1:0]   idx_s;
  int                     idx_int_s;
  logic [lg_els_lp-1:0]   next_ptr_s;
  logic [ang_width_p-1:0] ang_arr_s [els_p];

  for (genvar gk = 0; gk < els_p; gk++) begin : g_unpack
    assign ang_arr_s[gk] = ang_i[gk*ang_width_p +: ang_width_p];
  end

  // Round-robin search; walk farthest-first so the requester nearest rr_ptr wins
  always_comb begin
    grant_s   = '0;
    grant_v_s = 1'b0;
    idx_int_s = 0;
    idx_s     = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      idx_int_s = (int'(rr_ptr_r) + i) % els_p;
      idx_s     = idx_int_s[lg_els_lp-1:0];
      grant_v_s = grant_v_s | v_i[idx_s];
      grant_s   = v_i[idx_s] ? idx_s : grant_s;
    end
  end

  // Per-requester strobes decoded from the current state and grant/owner index
  always_comb begin
    ready_o = '0;
    v_o     = '0;
    for (int k = 0; k < els_p; k++) begin
      ready_o[k] = (state_r == eIDLE) && grant_v_s && (grant_s == lg_els_lp'(k));
      v_o[k]     = (state_r == eRETURN) && (owner_r == lg_els_lp'(k));
    end
  end

  assign next_ptr_s  = (owner_r == lg_els_lp'(els_p - 1)) ? lg_els_lp'(0)
                                                           : owner_r + lg_els_lp'(1);
  assign unit_v_o    = (state_r == eISSUE);
  assign unit_ang_o  = ang_r;
  // A result strobe outside eWAIT is a protocol error and is never acknowledged
  assign unit_yumi_o = (state_r == eWAIT) && unit_v_i;
  assign data_o      = data_r;
  assign busy_o      = (state_r != eIDLE);

  // Sequencing of one operation at a time plus ownership and payload capture
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= eIDLE;
      rr_ptr_r <= '0;
      owner_r  <= '0;
      ang_r    <= '0;
      data_r   <= '0;
    end else begin
      case (state_r)
        eIDLE: begin
          if (grant_v_s) begin
            ang_r   <= ang_arr_s[grant_s];
            owner_r <= grant_s;
            state_r <= eISSUE;
          end
        end
        eISSUE: begin
          if (unit_ready_i) begin
            state_r <= eWAIT;
          end
        end
        eWAIT: begin
          if (unit_v_i) begin
            data_r  <= unit_data_i;
            state_r <= eRETURN;
          end
        end
        eRETURN: begin
          if (yumi_i[owner_r]) begin
            rr_ptr_r <= next_ptr_s;
            state_r  <= eIDLE;
          end
        end
        default: begin
          state_r <= eIDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_activation_share_ctrl.sv
// Bench for bsg_activation_share_ctrl: stub activation unit returning ang+1,
// transaction-level model compared every cycle, plus directed scenarios.
module tb_bsg_activation_share_ctrl;

  localparam int EL = 4;
  localparam int AW = 21;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [EL-1:0]     v_i, ready_o, v_o, yumi_i;
  logic [EL*AW-1:0]  ang_i;
  logic [DW-1:0]     data_o, unit_data_i;
  logic              unit_v_o, unit_ready_i, unit_v_i, unit_yumi_o, busy_o;
  logic [AW-1:0]     unit_ang_o;

  int errors = 0;
  int checks = 0;

  bsg_activation_share_ctrl #(.els_p(EL), .ang_width_p(AW), .ans_width_p(DW)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ang_i(ang_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .unit_v_o(unit_v_o),
    .unit_ang_o(unit_ang_o), .unit_ready_i(unit_ready_i), .unit_v_i(unit_v_i),
    .unit_data_i(unit_data_i), .unit_yumi_o(unit_yumi_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Stub unit: result (arg+1) becomes valid lat cycles after the accepting cycle
  int             lat;
  logic           spur;
  logic [DW-1:0]  junk;
  logic           st_pend;
  int             st_cnt;
  logic [AW-1:0]  st_arg;

  always @(posedge clk) begin
    if (reset_i) begin
      st_pend <= 1'b0; st_cnt <= 0; st_arg <= '0;
    end else if (unit_yumi_o) begin
      st_pend <= 1'b0;
    end else if (unit_v_o && unit_ready_i) begin
      st_pend <= 1'b1; st_cnt <= lat - 1; st_arg <= unit_ang_o;
    end else if (st_pend && st_cnt > 0) begin
      st_cnt <= st_cnt - 1;
    end
  end
  assign unit_v_i    = st_pend ? (st_cnt == 0) : spur;
  assign unit_data_i = st_pend ? (DW'(st_arg) + 32'd1) : junk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [EL-1:0] onehot(input int k);
    return EL'(1) << k;
  endfunction

  function automatic int idx_of(input logic [EL-1:0] oh);
    for (int i = 0; i < EL; i++) if (oh[i]) return i;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [EL-1:0] req, input int ptr);
    for (int i = 0; i < EL; i++) if (req[(ptr + i) % EL]) return (ptr + i) % EL;
    return -1;
  endfunction

  // Model: an operation is owned, then issued, then holds a result until its owner consumes it
  bit            m_known = 1'b0;
  bit            m_busy, m_issued, m_have;
  int            m_ptr, m_owner;
  logic [AW-1:0] m_arg;
  logic [DW-1:0] m_data;

  initial begin : compare_proc
    logic [EL-1:0] s_v, s_y;
    logic          s_ur, s_uv, s_rst;
    logic [DW-1:0] s_ud;
    logic [EL*AW-1:0] s_ang;
    int g;
    forever begin
      @(negedge clk); #1;
      s_v = v_i; s_y = yumi_i; s_ur = unit_ready_i; s_uv = unit_v_i;
      s_ud = unit_data_i; s_rst = reset_i; s_ang = ang_i;
      g = rr_pick(s_v, m_ptr);
      if (m_known) begin
        chk("ready_o", ready_o, (!m_busy && g >= 0) ? onehot(g) : '0);
        chk("v_o", v_o, (m_busy && m_have) ? onehot(m_owner) : '0);
        chk("unit_v_o", unit_v_o, m_busy && !m_issued);
        chk("unit_ang_o", unit_ang_o, m_arg);
        chk("unit_yumi_o", unit_yumi_o, m_busy && m_issued && !m_have && s_uv);
        chk("busy_o", busy_o, m_busy);
        chk("data_o", data_o, m_data);
        if (m_busy && m_have) chk("data_o_result", data_o, DW'(m_arg) + 32'd1);
      end
      @(posedge clk);
      if (s_rst) begin
        m_known = 1'b1; m_busy = 1'b0; m_issued = 1'b0; m_have = 1'b0;
        m_ptr = 0; m_owner = 0; m_arg = '0; m_data = '0;
      end else if (m_known) begin
        if (!m_busy) begin
          if (g >= 0) begin
            m_busy = 1'b1; m_issued = 1'b0; m_have = 1'b0;
            m_owner = g; m_arg = s_ang[g*AW +: AW];
          end
        end else if (!m_issued) begin
          if (s_ur) m_issued = 1'b1;
        end else if (!m_have) begin
          if (s_uv) begin m_have = 1'b1; m_data = s_ud; end
        end else if (s_y[m_owner]) begin
          m_ptr = (m_owner + 1) % EL;
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic set_ang(input int k, input logic [AW-1:0] a);
    ang_i[k*AW +: AW] = a;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_i = 1'b1; v_i = '0; yumi_i = '0; unit_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk); reset_i = 1'b0;
  endtask

  // Entered at a negedge with v_i already driven; leaves at the negedge carrying the owner's yumi
  task automatic do_txn(input int stall, input int ydly, input logic [EL-1:0] next_v,
                        output int g);
    logic [AW-1:0] a;
    int n;
    g = -1;
    for (n = 0; n < 60; n++) begin
      if (n > 0) begin @(negedge clk); yumi_i = '0; end
      #2;
      if (ready_o != '0) begin g = idx_of(ready_o); break; end
    end
    if (g < 0) begin chk("grant_timeout", 64'd1, 64'd0); return; end
    a = ang_i[g*AW +: AW];
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); unit_ready_i = 1'b0; #2;
      chk("stall_unit_v", unit_v_o, 1'b1);
      chk("stall_unit_ang", unit_ang_o, a);
      chk("stall_ready", ready_o, '0);
    end
    @(negedge clk); unit_ready_i = 1'b1; #2;
    n = 0;
    while (v_o == '0 && n < 60) begin @(negedge clk); #2; n++; end
    chk("ret_v_o", v_o, onehot(g));
    chk("ret_data", data_o, DW'(a) + 32'd1);
    for (int d = 0; d < ydly; d++) begin
      @(negedge clk); yumi_i = ~onehot(g); #2;
      chk("hold_v_o", v_o, onehot(g));
      chk("hold_data", data_o, DW'(a) + 32'd1);
      chk("hold_ready", ready_o, '0);
    end
    @(negedge clk); yumi_i = onehot(g); v_i = next_v;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int g, n;
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    reset_i = 1'b1; v_i = '0; ang_i = '0; yumi_i = '0; unit_ready_i = 1'b1;
    spur = 1'b0; junk = '0; lat = 5;
    repeat (3) @(negedge clk);
    reset_i = 1'b0; #2;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_v_o", v_o, 4'b0000);
    chk("rst_unit_v", unit_v_o, 1'b0);
    chk("rst_data", data_o, 32'd0);

    // Single request, unit latency 5: result returns 7 cycles after the accept
    @(negedge clk); v_i = 4'b0001; set_ang(0, 21'd100); #2;
    chk("single_ready", ready_o, 4'b0001);
    @(negedge clk); v_i = '0; #2;
    chk("single_issue", unit_v_o, 1'b1);
    chk("single_ang", unit_ang_o, 21'd100);
    n = 1;
    while (v_o == '0 && n < 40) begin @(negedge clk); #2; n++; end
    chk("single_latency", n, 7);
    chk("single_v_o", v_o, 4'b0001);
    chk("single_data", data_o, 32'd101);
    @(negedge clk); yumi_i = 4'b0001; #2;
    @(negedge clk); yumi_i = '0; #2;
    chk("single_idle", busy_o, 1'b0);

    // Round robin with all four requesting
    do_reset();
    set_ang(0, 21'd10); set_ang(1, 21'd20); set_ang(2, 21'd30); set_ang(3, 21'd40);
    lat = 2; v_i = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      do_txn(0, 0, (t == 4) ? 4'b0000 : 4'b1111, g);
      chk("rr_order", g, rr_exp[t]);
    end

    // Pointer wrap from requester 3 back to 0
    do_reset();
    set_ang(3, 21'd777); v_i = 4'b1000;
    do_txn(0, 0, 4'b1001, g);
    chk("wrap_first", g, 3);
    do_txn(0, 0, 4'b0000, g);
    chk("wrap_second", g, 0);

    // Issue stall, withheld yumi with wrong-owner bits, then pointer advances past 2
    @(negedge clk); yumi_i = '0; set_ang(2, 21'd555); v_i = 4'b0100;
    do_txn(4, 6, 4'b1011, g);
    chk("bp_owner", g, 2);
    do_txn(0, 0, 4'b0000, g);
    chk("bp_next", g, 3);

    // Move pointer to 2, then reset while waiting on the unit
    @(negedge clk); yumi_i = '0; lat = 5; v_i = 4'b0010; set_ang(1, 21'd7);
    do_txn(0, 0, 4'b0000, g);
    chk("pre_rst_owner", g, 1);
    @(negedge clk); yumi_i = '0; v_i = 4'b0100; set_ang(2, 21'h1234); #2;
    chk("midop_grant", ready_o, 4'b0100);
    @(negedge clk); v_i = '0; #2;
    @(negedge clk); #2;
    chk("midop_wait_busy", busy_o, 1'b1);
    chk("midop_wait_unit_v", unit_v_o, 1'b0);
    @(negedge clk); reset_i = 1'b1; #2;
    @(negedge clk); reset_i = 1'b0; #2;
    chk("midop_busy", busy_o, 1'b0);
    chk("midop_v_o", v_o, 4'b0000);
    chk("midop_ready", ready_o, 4'b0000);
    @(negedge clk); v_i = 4'b1010; set_ang(1, 21'h42);
    do_txn(0, 0, 4'b0000, g);
    chk("post_rst_owner", g, 1);
    @(negedge clk); yumi_i = '0;

    // Randomized traffic, stalls, spurious unit strobes and occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      v_i = EL'($urandom);
      for (int k = 0; k < EL; k++) set_ang(k, AW'($urandom));
      yumi_i = EL'($urandom);
      unit_ready_i = ($urandom % 4) != 0;
      lat = $urandom_range(1, 4);
      spur = ($urandom % 3) == 0;
      junk = $urandom;
      reset_i = ($urandom % 300) == 0;
    end
    @(negedge clk); reset_i = 1'b0; v_i = '0; yumi_i = '0; spur = 1'b0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
